// File: rtl/present_pkg.sv
// Shared PRESENT constants: S-box tables, bit-permutation index helpers, FSM encoding.
// The inverse table and helpers are only referenced when PRESENT_DECRYPT_EN is defined.
package present_pkg;

  localparam int unsigned KEY_W_80   = 80;
  localparam int unsigned KEY_W_128  = 128;
  localparam int unsigned ROUNDS_MIN = 1;
  localparam int unsigned ROUNDS_MAX = 31;

  // Nibble n of each table holds S[n] (resp. S^-1[n]).
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    StIdle,
    StKeygen,
    StRun,
    StDone
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  // pLayer moves bit i to position p_idx(i).
  function automatic int unsigned p_idx(input int unsigned i);
    return (i == 63) ? 63 : ((i * 16) % 63);
  endfunction

  function automatic int unsigned p_inv_idx(input int unsigned i);
    return (i == 63) ? 63 : ((i * 4) % 63);
  endfunction

endpackage

// File: rtl/present_round.sv
// One combinational PRESENT round: key add, S-box layer, pLayer; or the inverse pair.
// The inverse path and the inv_i port exist only when PRESENT_DECRYPT_EN is defined.
module present_round
  import present_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [63:0] rk_i,
`ifdef PRESENT_DECRYPT_EN
  input  logic        inv_i,
`endif
  output logic [63:0] data_o
);

  logic [63:0] mixed;
  logic [63:0] fwd_s;
  logic [63:0] fwd_p;

  assign mixed = data_i ^ rk_i;

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign fwd_s[4*n +: 4] = sbox(mixed[4*n +: 4]);
  end

  for (genvar i = 0; i < 64; i++) begin : g_perm
    assign fwd_p[p_idx(i)] = fwd_s[i];
  end

`ifdef PRESENT_DECRYPT_EN
  logic [63:0] inv_p;
  logic [63:0] inv_s;

  for (genvar i = 0; i < 64; i++) begin : g_inv_perm
    assign inv_p[p_inv_idx(i)] = mixed[i];
  end

  for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
    assign inv_s[4*n +: 4] = inv_sbox(inv_p[4*n +: 4]);
  end

  assign data_o = inv_i ? inv_s : fwd_p;
`else
  assign data_o = fwd_p;
`endif

endmodule

// File: rtl/present_enc_param.sv
// PRESENT-80/128 cipher core, one round per clock, four-phase req/ack handshake.
// PRESENT_DECRYPT_EN adds the KEYGEN state, inverse round and inverse key schedule.
module present_enc_param
  import present_pkg::*;
#(
  parameter int unsigned KEY_W  = 80,
  parameter int unsigned ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             mode,
  input  logic [KEY_W-1:0] K,
  input  logic [63:0]      M,
  output logic             ack,
  output logic [63:0]      C,
  output logic             busy
);

  localparam int unsigned CntLsb    = (KEY_W == KEY_W_128) ? 62 : 15;
  localparam logic [5:0]  LastRound = 6'(ROUNDS);
  localparam logic [5:0]  WhitenCnt = 6'(ROUNDS + 1);

  if (!((KEY_W == KEY_W_80 || KEY_W == KEY_W_128) &&
        ROUNDS >= ROUNDS_MIN && ROUNDS <= ROUNDS_MAX)) begin : g_param_check
    $error("present_enc_param: KEY_W must be 80 or 128 and ROUNDS 1..31");
  end

  state_e           fsm_q, fsm_d;
  logic [63:0]      blk_q, blk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [63:0]      c_q, c_d;
  logic             ack_q, ack_d;
  logic [63:0]      rk;
  logic [63:0]      round_out;

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                              input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == KEY_W_128) begin
      r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    end
    r[CntLsb +: 5] = r[CntLsb +: 5] ^ rc;
    return r;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  logic mode_q, mode_d;

  // Undoes key_fwd for the same round counter: counter XOR, S-box, then rotate right 61.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                              input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = k;
    r[CntLsb +: 5] = r[CntLsb +: 5] ^ rc;
    r[KEY_W-1 -: 4] = inv_sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == KEY_W_128) begin
      r[KEY_W-5 -: 4] = inv_sbox(r[KEY_W-5 -: 4]);
    end
    return {r[60:0], r[KEY_W-1:61]};
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign rk = key_q[KEY_W-1 -: 64];

  present_round u_round (
    .data_i (blk_q),
    .rk_i   (rk),
`ifdef PRESENT_DECRYPT_EN
    .inv_i  (mode_q),
`endif
    .data_o (round_out)
  );

  always_comb begin
    fsm_d = fsm_q;
    blk_d = blk_q;
    key_d = key_q;
    cnt_d = cnt_q;
    c_d   = c_q;
    ack_d = ack_q;
`ifdef PRESENT_DECRYPT_EN
    mode_d = mode_q;
`endif
    case (fsm_q)
      StIdle: begin
        if (req) begin
          blk_d = M;
          key_d = K;
          cnt_d = 6'd1;
`ifdef PRESENT_DECRYPT_EN
          mode_d = mode;
          fsm_d  = mode ? StKeygen : StRun;
`else
          fsm_d  = StRun;
`endif
        end
      end
`ifdef PRESENT_DECRYPT_EN
      StKeygen: begin
        if (!req) begin
          fsm_d = StIdle;
        end else begin
          key_d = key_fwd(key_q, cnt_q[4:0]);
          if (cnt_q == LastRound) begin
            fsm_d = StRun;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
`endif
      StRun: begin
        if (!req) begin
          fsm_d = StIdle;
`ifdef PRESENT_DECRYPT_EN
        end else if (mode_q) begin
          // Counter runs ROUNDS..1; the cycle at 0 applies the final whitening key.
          if (cnt_q == 6'd0) begin
            c_d   = blk_q ^ rk;
            ack_d = 1'b1;
            fsm_d = StDone;
          end else begin
            blk_d = round_out;
            key_d = key_inv(key_q, cnt_q[4:0]);
            cnt_d = cnt_q - 6'd1;
          end
`endif
        end else if (cnt_q == WhitenCnt) begin
          c_d   = blk_q ^ rk;
          ack_d = 1'b1;
          fsm_d = StDone;
        end else begin
          blk_d = round_out;
          key_d = key_fwd(key_q, cnt_q[4:0]);
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: begin
        if (!req) begin
          ack_d = 1'b0;
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= StIdle;
      blk_q  <= '0;
      key_q  <= '0;
      cnt_q  <= '0;
      c_q    <= '0;
      ack_q  <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
      mode_q <= 1'b0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      ack_q  <= ack_d;
`ifdef PRESENT_DECRYPT_EN
      mode_q <= mode_d;
`endif
    end
  end

  assign ack  = ack_q;
  assign C    = c_q;
  assign busy = (fsm_q != StIdle) && (fsm_q != StDone);

endmodule

// File: doc/present_enc_param.md
PRESENT_ENC_PARAM -- requirements
Module: present_enc_param

Interface
REQ-001 SHALL have parameter KEY_W, default 80, key width; legal values 80 or 128 only.
REQ-002 SHALL have parameter ROUNDS, default 31, number of full rounds; legal range 1..31.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1, operation request, four-phase handshake.
REQ-006 SHALL have port mode, input, 1, 0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port K, input, KEY_W, cipher key.
REQ-008 SHALL have port M, input, 64, input block: plaintext when encrypting, ciphertext when decrypting.
REQ-009 SHALL have port ack, output, 1, result valid.
REQ-010 SHALL have port C, output, 64, result block, registered.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE and DONE.

Function
REQ-012 SHALL implement the FSM states IDLE, KEYGEN, RUN and DONE.
REQ-013 In IDLE with req=1, SHALL capture M, K and mode, and set round counter = 1.
  - Next state: RUN if mode=0; KEYGEN if mode=1.
REQ-014 In KEYGEN, SHALL apply one forward key-schedule step per cycle for ROUNDS cycles to reach the final round key, then enter RUN with counter = ROUNDS.
REQ-015 In RUN (encrypt), each cycle SHALL perform:
  - state <= pLayer(sbox(state ^ rk[KEY_W-1:KEY_W-64]))
  - key <= schedule(key, counter)
  - counter++
REQ-016 In RUN (decrypt), each cycle SHALL apply the exact inverse of REQ-015 and decrement the counter.
REQ-017 On the cycle completing round ROUNDS, SHALL load C with the whitened result, assert ack and enter DONE.
  - Encrypt latency: exactly ROUNDS+1 edges from the capture edge to ack high.
  - Decrypt latency: exactly 2*ROUNDS+1 edges.
REQ-018 The key schedule SHALL follow PRESENT:
  - Rotate left 61.
  - KEY_W=80: S-box on the top nibble.
  - KEY_W=128: S-box on the top two nibbles.
  - XOR the 5-bit counter into bits [19:15] (80) or [66:62] (128).
REQ-019 In DONE, ack and C SHALL hold stable while req=1; on req=0, SHALL drop ack and return to IDLE on the next edge.
REQ-020 req falling in KEYGEN or RUN SHALL abort the operation: IDLE on the next edge, ack stays 0, C unchanged.
REQ-021 Changes on M, K or mode after capture SHALL have no effect on the running operation.
REQ-022 A new request SHALL only be accepted from IDLE; req held high through DONE SHALL NOT restart the operation.

Reset
REQ-023 rst_n=0 SHALL asynchronously force:
  - state = IDLE
  - ack = 0, busy = 0
  - C = 64'h0
  - counter = 0
  - internal state and key registers = 0
REQ-024 Reset asserted mid-operation SHALL discard the operation; the first request after reset release SHALL behave as a fresh request.

Configuration
REQ-025 Macro PRESENT_DECRYPT_EN SHALL control the decryption datapath.
  - Defined: KEYGEN state, inverse S-box/pLayer and inverse key schedule compiled in; mode honoured.
  - Undefined: KEYGEN and inverse logic absent; mode ignored and treated as 0.

Structure
REQ-026 Package present_pkg SHALL hold:
  - SBOX and INV_SBOX tables
  - pLayer/inverse index functions
  - FSM state enum
  - KEY_W legality constants
REQ-027 SHALL contain one sub-module, present_round: combinational sbox+pLayer and inverse, selected by a direction input.
REQ-028 SHALL check KEY_W and ROUNDS with an elaboration-time assertion.

Verification
REQ-029 KEY_W=80, ROUNDS=31, M=0, K=0, mode=0: C=64'h5579C1387B228445, ack high exactly 32 edges after capture.
REQ-030 KEY_W=80, M=64'hFFFFFFFFFFFFFFFF, K=all ones, mode=0: C=64'h3333DCD3213210D2.
REQ-031 KEY_W=128, M=0, K=0, mode=0: C=64'h96DB702A2E6900AF.
REQ-032 PRESENT_DECRYPT_EN defined, KEY_W=80, M=64'hE72C46C0F5945049, K=all ones, mode=1: C=0, ack after 63 edges.
REQ-033 req dropped at round 10, then re-raised with new M: no ack from the aborted run; second result correct.
REQ-034 rst_n pulsed low at round 15: ack=0, C=0 immediately; next request yields the correct vector.
